// File: rtl/simd_issue_controller.sv
// Sequencer for the SIMD lanes: fetch/decode each instruction word, issue it, wait for all lanes, then retire.
// Latency: NOP 3 cycles, LOAD/STORE 4, arithmetic 4 + WAIT cycles; every output comes straight from a flop.
// Backpressure: holds in WAIT until every lane reports valid; gives up to ERR after TIMEOUT wait cycles.
module simd_issue_controller #(
    parameter  int N       = 16,
    parameter  int REGN    = 512,
    parameter  int TIMEOUT = 64,
    localparam int AW      = $clog2(REGN / 2)
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          START,
    input  logic [31:0]   INSTR,
    input  logic [N-1:0]  LANE_VALID,
    output logic          DONE,
    output logic          DOUT_MUX,
    output logic          ALU_START,
    output logic [2:0]    ALU_OP,
    output logic [AW-1:0] RD_ADDR_A,
    output logic [AW-1:0] RD_ADDR_B,
    output logic [AW-1:0] WR_ADDR,
    output logic          WR_EN,
    output logic          MAT_LOAD,
    output logic          BUSY,
    output logic          HALTED,
    output logic          ERROR,
    output logic [15:0]   RETIRED
);

    localparam int CW = $clog2(TIMEOUT);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_MUL   = 4'h4;
    localparam logic [3:0] OP_MAC   = 4'h5;
    localparam logic [3:0] OP_STORE = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_WB, S_HALT, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [7:0]    dest_q, dest_d;
    logic [7:0]    srca_q, srca_d;
    logic [7:0]    srcb_q, srcb_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [15:0]   retired_q, retired_d;
    logic          done_q, done_d;
    logic          dout_mux_q, dout_mux_d;
    logic          alu_start_q, alu_start_d;
    logic [2:0]    alu_op_q, alu_op_d;
    logic          wr_en_q, wr_en_d;
    logic          mat_load_q, mat_load_d;
    logic          busy_q, busy_d;
    logic          halted_q, halted_d;
    logic          error_q, error_d;
    logic          arith_d;

    // Low nibble of the instruction word carries no information.
    logic unused_instr_bits;
    assign unused_instr_bits = ^INSTR[3:0];

    // Next-state logic, field capture, wait counter and the next value of every registered output.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dest_d    = dest_q;
        srca_d    = srca_q;
        srcb_d    = srcb_q;
        wcnt_d    = '0;
        retired_d = retired_q;

        case (state_q)
            S_IDLE:   if (START) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                op_d   = INSTR[31:28];
                dest_d = INSTR[27:20];
                srca_d = INSTR[19:12];
                srcb_d = INSTR[11:4];
                case (INSTR[31:28])
                    OP_NOP:                                             state_d = S_WB;
                    OP_LOAD, OP_ADD, OP_SUB, OP_MUL, OP_MAC, OP_STORE: state_d = S_ISSUE;
                    OP_HALT:                                            state_d = S_HALT;
                    default:                                            state_d = S_ERR;
                endcase
            end
            S_ISSUE:  state_d = (op_q inside {OP_ADD, OP_SUB, OP_MUL, OP_MAC}) ? S_WAIT : S_WB;
            S_WAIT: begin
                // Completion beats timeout when both land in the same cycle.
                if (&LANE_VALID) begin
                    state_d = S_WB;
                end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
            end
            default:  state_d = state_q;
        endcase

        arith_d     = op_d inside {OP_ADD, OP_SUB, OP_MUL, OP_MAC};
        done_d      = (state_d == S_WB);
        wr_en_d     = (state_d == S_WB) && (arith_d || op_d == OP_LOAD);
        dout_mux_d  = (state_d == S_WB) && (op_d == OP_STORE);
        alu_start_d = (state_d == S_ISSUE) && arith_d;
        mat_load_d  = (state_d == S_ISSUE) && (op_d == OP_LOAD);
        alu_op_d    = ((state_d inside {S_ISSUE, S_WAIT, S_WB}) && arith_d) ? op_d[2:0] : 3'd0;
        busy_d      = !(state_d inside {S_IDLE, S_HALT, S_ERR});
        halted_d    = (state_d == S_HALT);
        error_d     = (state_d == S_ERR);
    end

    // Single state register for the FSM, captured fields and all registered outputs.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            dest_q      <= '0;
            srca_q      <= '0;
            srcb_q      <= '0;
            wcnt_q      <= '0;
            retired_q   <= '0;
            done_q      <= 1'b0;
            dout_mux_q  <= 1'b0;
            alu_start_q <= 1'b0;
            alu_op_q    <= '0;
            wr_en_q     <= 1'b0;
            mat_load_q  <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dest_q      <= dest_d;
            srca_q      <= srca_d;
            srcb_q      <= srcb_d;
            wcnt_q      <= wcnt_d;
            retired_q   <= retired_d;
            done_q      <= done_d;
            dout_mux_q  <= dout_mux_d;
            alu_start_q <= alu_start_d;
            alu_op_q    <= alu_op_d;
            wr_en_q     <= wr_en_d;
            mat_load_q  <= mat_load_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            error_q     <= error_d;
        end
    end

    assign DONE      = done_q;
    assign DOUT_MUX  = dout_mux_q;
    assign ALU_START = alu_start_q;
    assign ALU_OP    = alu_op_q;
    assign WR_EN     = wr_en_q;
    assign MAT_LOAD  = mat_load_q;
    assign BUSY      = busy_q;
    assign HALTED    = halted_q;
    assign ERROR     = error_q;
    assign RETIRED   = retired_q;
    assign RD_ADDR_A = AW'(srca_q);
    assign RD_ADDR_B = AW'(srcb_q);
    assign WR_ADDR   = AW'(dest_q);

endmodule

// File: doc/simd_issue_controller.md
# simd_issue_controller

Sequencing controller for the SIMD datapath: walks the instruction stream exposed by the fetch unit, decodes each 32-bit word, issues operations to the N vector lanes, waits for lane completion and pulses DONE to advance the program counter. Drives the fetch unit's DONE and DOUT_MUX inputs and the lane/register-file control strobes. HALT, illegal opcodes and lane timeouts stop the machine with sticky status.

## Interface
- N, 16, number of SIMD lanes
- REGN, 512, register-file depth; register address width is AW = $clog2(REGN/2)
- TIMEOUT, 64, maximum WAIT cycles before error (≥2)
- CLK  in  1  rising-edge clock
- RSTN  in  1  reset, asynchronous, active-low
- START  in  1  begin execution from IDLE (level, sampled in IDLE only)
- INSTR  in  32  instruction word from fetch unit; [31:28] opcode, [27:20] dest, [19:12] srcA, [11:4] srcB, [3:0] ignored
- LANE_VALID  in  N  per-lane completion flags for the current op
- DONE  out  1  one-cycle retire pulse; advances fetch PC
- DOUT_MUX  out  1  result bus enable toward fetch unit (STORE only)
- ALU_START  out  1  one-cycle issue strobe to lanes
- ALU_OP  out  3  lane op code, held from ISSUE through WB
- RD_ADDR_A, RD_ADDR_B, WR_ADDR  out  AW each  register addresses (low AW bits of srcA/srcB/dest)
- WR_EN  out  1  register-file write strobe
- MAT_LOAD  out  1  matrix-broadcast capture strobe
- BUSY  out  1  high in any state except IDLE, HALT, ERR
- HALTED  out  1  sticky, HALT executed
- ERROR  out  1  sticky, illegal opcode or timeout
- RETIRED  out  16  retired-instruction count, saturates at 16'hFFFF

## Operation
- States: IDLE, FETCH, DECODE, ISSUE, WAIT, WB, HALT, ERR.
- IDLE: START=1 -> FETCH.
- FETCH: one cycle for synchronous instruction read -> DECODE.
- DECODE: register INSTR fields. Opcode 0 NOP -> WB; 1 LOAD, 2 ADD, 3 SUB, 4 MUL, 5 MAC, 6 STORE -> ISSUE; F HALT -> HALT; any other -> ERR.
- ISSUE: ALU_START=1 for ADD/SUB/MUL/MAC (ALU_OP = opcode[2:0]); MAT_LOAD=1 for LOAD. Arithmetic -> WAIT; LOAD/STORE -> WB.
- WAIT: clear the wait counter on entry; leave for WB when &LANE_VALID=1. If the counter reaches TIMEOUT with &LANE_VALID=0 -> ERR. A completion seen in the same cycle the counter reaches TIMEOUT wins: go to WB.
- WB: DONE=1. WR_EN=1 for ADD/SUB/MUL/MAC/LOAD. DOUT_MUX=1 for STORE. NOP asserts DONE only. RETIRED increments (saturating). Next state FETCH.
- HALT: HALTED=1, no DONE, PC not advanced. Held until reset; START ignored.
- ERR: ERROR=1, no DONE. Held until reset.
- Register addresses are combinational from the registered fields and are valid ISSUE through WB.

## Timing
- Reset (asynchronous, any state, mid-instruction included): state=IDLE. DONE, DOUT_MUX, ALU_START, ALU_OP, WR_EN, MAT_LOAD, BUSY, HALTED, ERROR = 0. Addresses = 0. RETIRED = 0. Wait counter = 0.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- Latency: NOP 3 cycles (FETCH, DECODE, WB). LOAD/STORE 4 cycles. Arithmetic 4 + k cycles, where k ≥ 1 is the number of WAIT cycles.
- DONE, WR_EN, DOUT_MUX and MAT_LOAD are exactly one cycle wide. The PC increments on the edge that ends WB, so the following FETCH addresses the next word.
- LANE_VALID is ignored outside WAIT. Partial valid masks never retire.

## Test plan
- Reset, then START=1 with NOP at PC0 and HALT at PC1 -> DONE pulses once, 3 cycles after START; HALTED=1; RETIRED=1; BUSY=0.
- ADD (0x2_05_01_02_0) with LANE_VALID=all-ones 2 cycles after ALU_START -> ALU_OP=2, RD_ADDR_A=1, RD_ADDR_B=2, WR_ADDR=5; WR_EN and DONE high together in one cycle; total 6 cycles.
- STORE -> DOUT_MUX=1 for exactly the DONE cycle and WR_EN=0. LOAD -> MAT_LOAD in ISSUE, WR_EN in WB.
- MUL with LANE_VALID=16'h7FFF held -> ERR after TIMEOUT=64 WAIT cycles; ERROR=1, no DONE. Repeat with all-ones arriving on the 64th cycle -> WB, no error.
- Opcode 0x9 -> ERROR=1 two cycles after FETCH, no DONE. Subsequent START ignored.
- RSTN deasserted during WAIT -> all outputs 0 immediately (asynchronously). RETIRED=0; restart runs the program normally.
